operand_unswap_queue: RTL

Restores the original operand order of result pairs leaving the linearizer/normalizer datapath. When an operand pair enters the datapath, the input swap stage records its select bit here. When the matching result pair returns, this block pops that bit and un-swaps the pair, so downstream logic sees results in the order the operands arrived. Select bits are held in-order in a small FIFO, so several pairs can be in flight at once.

---
 rtl/operand_unswap_queue_if.sv | 31 +++
 rtl/operand_unswap_queue.sv | 121 ++++++++++++
 2 files changed

// File: rtl/operand_unswap_queue_if.sv
// Operand unswap queue bus.
// Groups the swap-record side (push/swap/full/empty), the result side
// (res_valid/R0/R1 in, S0/S1/valid out) and the sticky error flags.
//   master : drives pushes and result pairs, observes restored results and flags
//   slave  : the queue itself
interface operand_unswap_queue_if #(
    parameter int unsigned W = 8
);
    logic         push_i;
    logic         swap_i;
    logic         full_o;
    logic         empty_o;
    logic         res_valid_i;
    logic [W-1:0] R0_i;
    logic [W-1:0] R1_i;
    logic [W-1:0] S0_o;
    logic [W-1:0] S1_o;
    logic         valid_o;
    logic         overflow_o;
    logic         underflow_o;

    modport master (
        output push_i, swap_i, res_valid_i, R0_i, R1_i,
        input  full_o, empty_o, S0_o, S1_o, valid_o, overflow_o, underflow_o
    );

    modport slave (
        input  push_i, swap_i, res_valid_i, R0_i, R1_i,
        output full_o, empty_o, S0_o, S1_o, valid_o, overflow_o, underflow_o
    );
endinterface

// File: rtl/operand_unswap_queue.sv
// Operand unswap queue.
// Records the input swap-stage select bit of each operand pair entering the
// datapath and, when the matching result pair returns, pops that bit and puts
// the results back into the original operand order.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : slave side of operand_unswap_queue_if
//          push_i/swap_i      record a select bit (1 = passed straight, 0 = exchanged)
//          full_o/empty_o     occupancy, combinational from the registered count
//          res_valid_i/R0_i/R1_i  returning result pair, pops one select bit
//          S0_o/S1_o/valid_o  restored results, registered, valid_o pulses per pop
//          overflow_o/underflow_o  sticky error flags, cleared only by rst
module operand_unswap_queue #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    operand_unswap_queue_if.slave   bus
);
    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CntW = AW + 1;
    localparam logic [CntW-1:0] FullCnt = DEPTH[CntW-1:0];

    logic [DEPTH-1:0] mem_q, mem_d;
    logic [AW-1:0]    wp_q, wp_d;
    logic [AW-1:0]    rp_q, rp_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [W-1:0]     s0_q, s0_d;
    logic [W-1:0]     s1_q, s1_d;
    logic             valid_q, valid_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic pop_acc;
    logic push_acc;
    logic sel;

    always_comb begin
        mem_d       = mem_q;
        wp_d        = wp_q;
        rp_d        = rp_q;
        count_d     = count_q;
        s0_d        = s0_q;
        s1_d        = s1_q;
        valid_d     = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        // Pop decision uses the pre-edge count: no push-to-pop bypass.
        pop_acc  = bus.res_valid_i && (count_q != '0);
        // A full queue can still take a push when a pop frees a slot this cycle.
        push_acc = bus.push_i && ((count_q != FullCnt) || pop_acc);
        sel      = mem_q[rp_q];

        if (pop_acc) begin
            if (sel) begin
                s0_d = bus.R0_i;
                s1_d = bus.R1_i;
            end else begin
                s0_d = bus.R1_i;
                s1_d = bus.R0_i;
            end
            rp_d    = rp_q + AW'(1);
            valid_d = 1'b1;
        end else if (bus.res_valid_i) begin
            underflow_d = 1'b1;
        end

        if (push_acc) begin
            // When full with a pop, wp == rp; the pop above already read the old bit.
            mem_d[wp_q] = bus.swap_i;
            wp_d        = wp_q + AW'(1);
        end else if (bus.push_i) begin
            overflow_d = 1'b1;
        end

        unique case ({push_acc, pop_acc})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q        <= '0;
            rp_q        <= '0;
            count_q     <= '0;
            s0_q        <= '0;
            s1_q        <= '0;
            valid_q     <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            count_q     <= count_d;
            s0_q        <= s0_d;
            s1_q        <= s1_d;
            valid_q     <= valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage contents are meaningless after reset, so no reset here.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.full_o      = (count_q == FullCnt);
    assign bus.empty_o     = (count_q == '0);
    assign bus.S0_o        = s0_q;
    assign bus.S1_o        = s1_q;
    assign bus.valid_o     = valid_q;
    assign bus.overflow_o  = overflow_q;
    assign bus.underflow_o = underflow_q;

endmodule
